// File: rtl/demux2_buf_if.sv
// Handshake bundle for demux2_buf: one producer stream in, two consumer lanes out.
// The master side (producer and consumers) drives requests; the slave side is the demux.
interface demux2_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] d;
  logic             s;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic             valid0_o;
  logic             valid1_o;
  logic             ready0_i;
  logic             ready1_i;
  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;

  modport master (
    output d, s, valid_i, ready0_i, ready1_i,
    input  ready_o, y0, y1, valid0_o, valid1_o, count0, count1
  );

  modport slave (
    input  d, s, valid_i, ready0_i, ready1_i,
    output ready_o, y0, y1, valid0_o, valid1_o, count0, count1
  );
endinterface

// File: rtl/demux2_buf.sv
// Registered 1-to-2 demultiplexer: the select bit steers each accepted word into one
// of two independent lane FIFOs, so a stalled consumer never blocks the other lane.
module demux2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         reset,
  demux2_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem  [2][DEPTH];
  logic [PW-1:0]    wptr [2];
  logic [PW-1:0]    rptr [2];
  logic [CW-1:0]    cnt  [2];
  logic [1:0]       full;
  logic [1:0]       push;
  logic [1:0]       pop;

  always_comb begin
    for (int k = 0; k < 2; k++) full[k] = (cnt[k] == CW'(DEPTH));
  end

  // Full lanes refuse a push even when they pop in the same cycle.
  assign bus.ready_o = !full[bus.s];

  always_comb begin
    push         = '0;
    push[bus.s]  = bus.valid_i && !full[bus.s];
    pop[0]       = (cnt[0] != '0) && bus.ready0_i;
    pop[1]       = (cnt[1] != '0) && bus.ready1_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) wptr[k] <= wptr[k] + PW'(1);
        if (pop[k])  rptr[k] <= rptr[k] + PW'(1);
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + CW'(1);
          2'b01:   cnt[k] <= cnt[k] - CW'(1);
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) mem[k][wptr[k]] <= bus.d;
    end
  end

  assign bus.valid0_o = (cnt[0] != '0);
  assign bus.valid1_o = (cnt[1] != '0);
  assign bus.y0       = (cnt[0] != '0) ? mem[0][rptr[0]] : '0;
  assign bus.y1       = (cnt[1] != '0) ? mem[1][rptr[1]] : '0;
  assign bus.count0   = cnt[0];
  assign bus.count1   = cnt[1];
endmodule
